// File: rtl/wide_incdec_pkg.sv
// Shared types for the wide counter bank: op codes
// and the response flag bundle.
package wide_incdec_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_LOAD = 2'd3
    } op_code_e;

    // Width-independent part of a response.
    typedef struct packed {
        logic wrap;
        logic err;
    } rsp_flags_t;

endpackage

// File: rtl/wide_incdec_unit.sv
// Full-width add/sub of a zero-extended step with carry/borrow
// out and optional clamp. Ports: cur_i, step_i, dec_i -> res_o, wrap_o.
module wide_incdec_unit
    import wide_incdec_pkg::*;
#(
    parameter int WIDTH    = 95,
    parameter int STEP_W   = 8,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0]  cur_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              dec_i,
    output logic [WIDTH-1:0]  res_o,
    output logic              wrap_o
);

    logic [STEP_W-1:0] step_eff;
    logic [WIDTH:0]    ext;
    logic [WIDTH:0]    sum;

    always_comb begin
        // A zero step would make the op a no-op; treat it as 1.
        step_eff = (step_i == '0) ? STEP_W'(1) : step_i;
        ext      = (WIDTH+1)'(step_eff);
        // One extra bit holds carry (INC) or borrow (DEC).
        sum      = dec_i ? ({1'b0, cur_i} - ext)
                         : ({1'b0, cur_i} + ext);
        wrap_o   = sum[WIDTH];
        res_o    = sum[WIDTH-1:0];
        if (SATURATE != 0 && wrap_o) begin
            res_o = dec_i ? '0 : '1;
        end
    end

endmodule

// File: rtl/wide_incdec_bank.sv
// Bank of wide counters with INC/DEC/LOAD, one-entry response register.
// Ports: op_* command (valid/ready), rsp_* response (valid/ready), cnt_zero.
module wide_incdec_bank
    import wide_incdec_pkg::*;
#(
    parameter int WIDTH    = 95,
    parameter int CHANNELS = 4,
    parameter int STEP_W   = 8,
    parameter int SATURATE = 0,
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [CHW-1:0]      op_chan,
    input  logic [1:0]          op_code,
    input  logic                op_post,
    input  logic [STEP_W-1:0]   op_step,
    input  logic [WIDTH-1:0]    op_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [CHW-1:0]      rsp_chan,
    output logic [WIDTH-1:0]    rsp_value,
    output logic                rsp_wrap,
    output logic                rsp_err,
    output logic [CHANNELS-1:0] cnt_zero
);

    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] zero_q, zero_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [CHW-1:0]   rsp_chan_q, rsp_chan_d;
    logic [WIDTH-1:0] rsp_value_q, rsp_value_d;
    rsp_flags_t       rsp_flags_q, rsp_flags_d;

    logic             accept, chan_ok, wr_en, nxt_wrap;
    logic             unit_wrap;
    logic [CHW-1:0]   sel;
    logic [WIDTH-1:0] cur, nxt, unit_res;
    op_code_e         code;

    assign op_ready = !rsp_valid_q || rsp_ready;
    assign accept   = op_valid && op_ready;
    assign chan_ok  = {1'b0, op_chan} < (CHW+1)'(CHANNELS);
    assign sel      = chan_ok ? op_chan : '0;
    assign cur      = cnt_q[sel];
    assign code     = op_code_e'(op_code);

    wide_incdec_unit #(
        .WIDTH    (WIDTH),
        .STEP_W   (STEP_W),
        .SATURATE (SATURATE)
    ) u_unit (
        .cur_i  (cur),
        .step_i (op_step),
        .dec_i  (code == OP_DEC),
        .res_o  (unit_res),
        .wrap_o (unit_wrap)
    );

    always_comb begin
        nxt      = cur;
        nxt_wrap = 1'b0;
        wr_en    = 1'b0;
        case (code)
            OP_INC, OP_DEC: begin
                nxt      = unit_res;
                nxt_wrap = unit_wrap;
                wr_en    = 1'b1;
            end
            OP_LOAD: begin
                nxt   = op_data;
                wr_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Zero flags are taken from the post-update value.
    always_comb begin
        cnt_d = cnt_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (accept && chan_ok && wr_en && sel == CHW'(c)) begin
                cnt_d[c] = nxt;
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            zero_d[c] = (cnt_d[c] == '0);
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_chan_d  = rsp_chan_q;
        rsp_value_d = rsp_value_q;
        rsp_flags_d = rsp_flags_q;
        if (accept) begin
            rsp_valid_d      = 1'b1;
            rsp_chan_d       = op_chan;
            rsp_value_d      = '0;
            if (chan_ok) begin
                rsp_value_d = op_post ? nxt : cur;
            end
            rsp_flags_d.wrap = chan_ok && nxt_wrap;
            rsp_flags_d.err  = !chan_ok;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= '0;
            end
            zero_q      <= '1;
            rsp_valid_q <= 1'b0;
            rsp_chan_q  <= '0;
            rsp_value_q <= '0;
            rsp_flags_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_chan_q  <= rsp_chan_d;
            rsp_value_q <= rsp_value_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_chan  = rsp_chan_q;
    assign rsp_value = rsp_value_q;
    assign rsp_wrap  = rsp_flags_q.wrap;
    assign rsp_err   = rsp_flags_q.err;
    assign cnt_zero  = zero_q;

endmodule

// File: tb/tb_wide_incdec_bank.sv
// Bench for wide_incdec_bank: a wrapping 4-channel instance and a
// saturating 3-channel instance share stimulus, checked against a model.
module tb_wide_incdec_bank;

    localparam int W = 95;
    localparam logic [W-1:0] ALL1 = '1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic op_valid = 1'b0;
    logic [1:0] op_chan = '0;
    logic [1:0] op_code = '0;
    logic op_post = 1'b0;
    logic [7:0] op_step = '0;
    logic [W-1:0] op_data = '0;
    logic rsp_ready = 1'b1;

    logic op_ready0, op_ready1;
    logic rsp_valid0, rsp_valid1;
    logic [1:0] rsp_chan0, rsp_chan1;
    logic [W-1:0] rsp_value0, rsp_value1;
    logic rsp_wrap0, rsp_wrap1;
    logic rsp_err0, rsp_err1;
    logic [3:0] cnt_zero0;
    logic [2:0] cnt_zero1;

    int tests_run = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wide_incdec_bank #(
        .WIDTH(W), .CHANNELS(4), .STEP_W(8), .SATURATE(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready0),
        .op_chan(op_chan), .op_code(op_code),
        .op_post(op_post), .op_step(op_step),
        .op_data(op_data),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
        .rsp_chan(rsp_chan0), .rsp_value(rsp_value0),
        .rsp_wrap(rsp_wrap0), .rsp_err(rsp_err0),
        .cnt_zero(cnt_zero0)
    );

    wide_incdec_bank #(
        .WIDTH(W), .CHANNELS(3), .STEP_W(8), .SATURATE(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready1),
        .op_chan(op_chan), .op_code(op_code),
        .op_post(op_post), .op_step(op_step),
        .op_data(op_data),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_chan(rsp_chan1), .rsp_value(rsp_value1),
        .rsp_wrap(rsp_wrap1), .rsp_err(rsp_err1),
        .cnt_zero(cnt_zero1)
    );

    task automatic chk(input string name,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [1:0]   chan;
        logic [W-1:0] value;
        logic         wrap;
        logic         err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [W-1:0] m0 [4];
    logic [W-1:0] m1 [4];

    function automatic exp_t mk_exp(input bit sat, input int nch,
                                    input logic [W-1:0] old,
                                    output logic [W-1:0] n,
                                    output bit wr);
        exp_t e;
        logic [W-1:0] st;
        st = (op_step == 0) ? W'(1) : W'(op_step);
        e.chan = op_chan;
        e.err = (int'(op_chan) >= nch);
        e.wrap = 1'b0;
        n = old;
        wr = 1'b0;
        if (e.err) begin
            e.value = '0;
            return e;
        end
        case (op_code)
            2'd1: begin
                e.wrap = (ALL1 - old) < st;
                n = old + st;
                if (sat && e.wrap) n = ALL1;
                wr = 1'b1;
            end
            2'd2: begin
                e.wrap = old < st;
                n = old - st;
                if (sat && e.wrap) n = '0;
                wr = 1'b1;
            end
            2'd3: begin
                n = op_data;
                wr = 1'b1;
            end
            default: ;
        endcase
        e.value = op_post ? n : old;
        return e;
    endfunction

    always @(negedge clk) begin
        logic exp_rdy;
        logic [W-1:0] n;
        bit wr;
        exp_t e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            for (int c = 0; c < 4; c++) begin
                m0[c] = '0;
                m1[c] = '0;
            end
            chk("rst_valid0", W'(rsp_valid0), 0);
            chk("rst_valid1", W'(rsp_valid1), 0);
            chk("rst_zero0", W'(cnt_zero0), 4'hF);
            chk("rst_zero1", W'(cnt_zero1), 3'h7);
        end else begin
            exp_rdy = (q0.size() == 0) || rsp_ready;
            chk("ready0", W'(op_ready0), W'(exp_rdy));
            chk("ready1", W'(op_ready1), W'(exp_rdy));
            chk("valid0", W'(rsp_valid0), W'(q0.size() != 0));
            chk("valid1", W'(rsp_valid1), W'(q1.size() != 0));
            if (q0.size() != 0) begin
                chk("chan0", W'(rsp_chan0), W'(q0[0].chan));
                chk("value0", rsp_value0, q0[0].value);
                chk("wrap0", W'(rsp_wrap0), W'(q0[0].wrap));
                chk("err0", W'(rsp_err0), W'(q0[0].err));
            end
            if (q1.size() != 0) begin
                chk("chan1", W'(rsp_chan1), W'(q1[0].chan));
                chk("value1", rsp_value1, q1[0].value);
                chk("wrap1", W'(rsp_wrap1), W'(q1[0].wrap));
                chk("err1", W'(rsp_err1), W'(q1[0].err));
            end
            for (int c = 0; c < 4; c++) begin
                chk("zero0", W'(cnt_zero0[c]), W'(m0[c] == 0));
            end
            for (int c = 0; c < 3; c++) begin
                chk("zero1", W'(cnt_zero1[c]), W'(m1[c] == 0));
            end
            if (q0.size() != 0 && rsp_ready) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (op_valid && exp_rdy) begin
                e = mk_exp(1'b0, 4, m0[op_chan], n, wr);
                if (wr) m0[op_chan] = n;
                q0.push_back(e);
                e = mk_exp(1'b1, 3, m1[op_chan], n, wr);
                if (wr) m1[op_chan] = n;
                q1.push_back(e);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic op(input logic [1:0] ch, input logic [1:0] code,
                      input logic post, input logic [7:0] step,
                      input logic [W-1:0] data);
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        op_chan = ch;
        op_code = code;
        op_post = post;
        op_step = step;
        op_data = data;
        #3;
        chk("task_ready", W'(op_ready0), 1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    logic [1:0] s_ch [8] = '{0, 0, 0, 1, 0, 3, 2, 0};
    logic [1:0] s_op [8] = '{3, 1, 2, 0, 1, 2, 1, 2};
    logic [7:0] s_st [8] = '{0, 7, 3, 0, 255, 0, 9, 200};

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("lit_rst_valid", W'(rsp_valid0), 0);
        chk("lit_rst_value", rsp_value0, 0);
        chk("lit_rst_zero", W'(cnt_zero0), 4'hF);

        op(0, 3, 1, 0, ALL1);
        chk("lit_load_val", rsp_value0, ALL1);
        chk("lit_load_zero0", W'(cnt_zero0), 4'b1110);
        chk("lit_load_zero1", W'(cnt_zero1), 3'b110);

        op(0, 1, 1, 1, 0);
        chk("lit_incwrap_val", rsp_value0, 0);
        chk("lit_incwrap_w", W'(rsp_wrap0), 1);
        chk("lit_incwrap_z", W'(cnt_zero0), 4'hF);
        chk("lit_incsat_val", rsp_value1, ALL1);
        chk("lit_incsat_w", W'(rsp_wrap1), 1);

        op(0, 2, 0, 1, 0);
        chk("lit_decpre_val", rsp_value0, 0);
        chk("lit_decpre_w", W'(rsp_wrap0), 1);
        op(0, 0, 0, 0, 0);
        chk("lit_nop_val", rsp_value0, ALL1);
        chk("lit_nop_w", W'(rsp_wrap0), 0);
        chk("lit_nop_sat", rsp_value1, ALL1 - 1);

        op(1, 3, 1, 0, ALL1 - 2);
        op(1, 1, 1, 5, 0);
        chk("lit_sat_inc", rsp_value1, ALL1);
        chk("lit_sat_inc_w", W'(rsp_wrap1), 1);
        chk("lit_mod_inc", rsp_value0, 2);
        op(1, 3, 1, 0, 3);
        op(1, 2, 1, 8, 0);
        chk("lit_sat_dec", rsp_value1, 0);
        chk("lit_sat_dec_w", W'(rsp_wrap1), 1);
        chk("lit_mod_dec", rsp_value0, ALL1 - 4);

        op(2, 3, 1, 0, 95'h0_FFFFFFFF_FFFFFFFF);
        op(2, 1, 1, 1, 0);
        chk("lit_limb_inc", rsp_value0, 95'h1_00000000_00000000);
        chk("lit_limb_inc_w", W'(rsp_wrap0), 0);
        op(2, 2, 1, 1, 0);
        chk("lit_limb_dec", rsp_value1, 95'h0_FFFFFFFF_FFFFFFFF);

        op(3, 3, 1, 0, 10);
        op(3, 2, 1, 0, 0);
        chk("lit_step0", rsp_value0, 9);
        chk("lit_bad_err", W'(rsp_err1), 1);
        chk("lit_bad_val", rsp_value1, 0);
        chk("lit_bad_w", W'(rsp_wrap1), 0);

        // Stall: consumer not ready for 3 cycles.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        op_valid = 1'b1;
        op_chan = 2;
        op_code = 1;
        op_post = 1;
        op_step = 1;
        @(posedge clk);
        #1;
        op_step = 3;
        repeat (3) begin
            @(negedge clk);
            chk("lit_stall_rdy", W'(op_ready0), 0);
            chk("lit_stall_val", rsp_value0, 95'h1_00000000_00000000);
            @(posedge clk);
        end
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        chk("lit_stall_after", rsp_value0, 95'h1_00000000_00000003);

        // Streaming, back-to-back on the same channel.
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            op_valid = 1'b1;
            op_chan = s_ch[i];
            op_code = s_op[i];
            op_post = i[0];
            op_step = s_st[i];
            op_data = W'(100 + i);
            @(posedge clk);
        end
        #1 op_valid = 1'b0;

        // Reset in the middle of traffic.
        op_valid = 1'b1;
        op_chan = 1;
        op_code = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        op_valid = 1'b0;
        #1;
        chk("lit_midrst_valid", W'(rsp_valid0), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            op(2'(c), 0, 0, 0, 0);
            chk("lit_postrst_val", rsp_value0, 0);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
